// File: rtl/tt_um_jleugeri_ttt_pkg.sv
// tt_um_jleugeri_ttt_pkg: shared types and token arithmetic.
// TTT_DEMUX_SATURATE_EN selects clamping instead of two's-complement wrap in tok_add.
package tt_um_jleugeri_ttt_pkg;

    typedef enum logic [1:0] {
        CONN_NONE = 2'b00,
        CONN_GOOD = 2'b01,
        CONN_BAD  = 2'b10
    } conn_t;

    typedef enum logic [2:0] {IDLE, GO, WAIT, SCAN, NEXT, PUBLISH} demux_state_t;

    // Result is meant to be truncated to w bits by the caller.
    function automatic int tok_add(input int acc, input int sign, input int w);
        int s;
        s = acc + sign;
`ifdef TTT_DEMUX_SATURATE_EN
        return (s > (1 << (w - 1)) - 1) ? (1 << (w - 1)) - 1 : (s < -(1 << (w - 1))) ? -(1 << (w - 1)) : s;
`else
        return (s <<< (32 - w)) >>> (32 - w);
`endif
    endfunction

endpackage

// File: rtl/tt_um_jleugeri_ttt_accum.sv
// tt_um_jleugeri_ttt_accum: bank of per-target good/bad token accumulators with synchronous clear.
module tt_um_jleugeri_ttt_accum
    import tt_um_jleugeri_ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS  = 10,
    parameter int NEW_TOKENS_BITS = 4,
    localparam int IDX_W = $clog2(NUM_PROCESSORS)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      add_en,
    input  logic [IDX_W-1:0]                          tgt,
    input  logic                                      sel_bad,
    input  logic signed [1:0]                         sign,
    input  logic                                      clear,
    output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0] good_vals,
    output logic [NUM_PROCESSORS*NEW_TOKENS_BITS-1:0] bad_vals
);

    logic signed [NEW_TOKENS_BITS-1:0] good [NUM_PROCESSORS];
    logic signed [NEW_TOKENS_BITS-1:0] bad  [NUM_PROCESSORS];

    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int i = 0; i < NUM_PROCESSORS; i++) begin
                good[i] <= '0;
                bad[i]  <= '0;
            end
        end else if (add_en) begin
            if (sel_bad)
                bad[tgt] <= NEW_TOKENS_BITS'(tok_add(int'(bad[tgt]), int'(sign), NEW_TOKENS_BITS));
            else
                good[tgt] <= NEW_TOKENS_BITS'(tok_add(int'(good[tgt]), int'(sign), NEW_TOKENS_BITS));
        end
    end

    for (genvar i = 0; i < NUM_PROCESSORS; i++) begin : g_pack
        assign good_vals[i*NEW_TOKENS_BITS +: NEW_TOKENS_BITS] = good[i];
        assign bad_vals[i*NEW_TOKENS_BITS +: NEW_TOKENS_BITS]  = bad[i];
    end

endmodule

// File: rtl/tt_um_jleugeri_ttt_demux.sv
// tt_um_jleugeri_ttt_demux: receive end of the TTT mux handshake; sweeps sources, fans signed events
// through a connection table into token accumulators and publishes them. Option: TTT_DEMUX_SATURATE_EN.
module tt_um_jleugeri_ttt_demux
    import tt_um_jleugeri_ttt_pkg::*;
#(
    parameter int NUM_PROCESSORS  = 10,
    parameter int NEW_TOKENS_BITS = 4,
    localparam int IDX_W = $clog2(NUM_PROCESSORS),
    localparam int TW    = NUM_PROCESSORS * NEW_TOKENS_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_in,
    output logic             mux_go_out,
    output logic             mux_next_out,
    input  logic             mux_hot_in,
    input  logic             mux_done_in,
    input  logic [IDX_W-1:0] src_idx_in,
    input  logic             src_tstart_in,
    input  logic             src_tstop_in,
    input  logic             cfg_we,
    input  logic [IDX_W-1:0] cfg_src,
    input  logic [IDX_W-1:0] cfg_tgt,
    input  logic [1:0]       cfg_conn,
    output logic [TW-1:0]    new_good_tokens,
    output logic [TW-1:0]    new_bad_tokens,
    output logic             enable
);

    localparam logic [IDX_W:0] NP = (IDX_W + 1)'(NUM_PROCESSORS);

    demux_state_t      state, state_nxt;
    logic [1:0]        conn_tbl [NUM_PROCESSORS][NUM_PROCESSORS];
    logic [IDX_W-1:0]  src, tgt;
    logic signed [1:0] sign, sign_in;
    logic [1:0]        conn;
    logic [TW-1:0]     good_vals, bad_vals;

    assign sign_in      = $signed({1'b0, src_tstart_in}) - $signed({1'b0, src_tstop_in});
    assign conn         = (state == SCAN) ? conn_tbl[src][tgt] : CONN_NONE;
    assign mux_go_out   = state == GO;
    assign mux_next_out = state == NEXT;

    always_ff @(posedge clk) begin
        state <= !rst_n ? IDLE : state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = tick_in ? GO : IDLE;
            GO:      state_nxt = WAIT;
            WAIT:    state_nxt = mux_done_in ? PUBLISH
                               : !mux_hot_in ? WAIT
                               : (sign_in == 2'sd0 || {1'b0, src_idx_in} >= NP) ? NEXT : SCAN;
            SCAN:    state_nxt = (tgt == IDX_W'(NUM_PROCESSORS - 1)) ? NEXT : SCAN;
            NEXT:    state_nxt = WAIT;
            PUBLISH: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            src             <= '0;
            tgt             <= '0;
            sign            <= '0;
            enable          <= 1'b0;
            new_good_tokens <= '0;
            new_bad_tokens  <= '0;
            for (int i = 0; i < NUM_PROCESSORS; i++)
                for (int j = 0; j < NUM_PROCESSORS; j++)
                    conn_tbl[i][j] <= CONN_NONE;
        end else begin
            enable <= state == PUBLISH;
            if (state == PUBLISH) begin
                new_good_tokens <= good_vals;
                new_bad_tokens  <= bad_vals;
            end
            if (state == WAIT && !mux_done_in && mux_hot_in) begin
                src  <= src_idx_in;
                sign <= sign_in;
                tgt  <= '0;
            end else if (state == SCAN) begin
                tgt <= tgt + 1'b1;
            end
            // Table is only writable between sweeps so a scan never sees a half-updated row.
            if (state == IDLE && cfg_we && {1'b0, cfg_src} < NP && {1'b0, cfg_tgt} < NP)
                conn_tbl[cfg_src][cfg_tgt] <= cfg_conn;
        end
    end

    tt_um_jleugeri_ttt_accum #(
        .NUM_PROCESSORS (NUM_PROCESSORS),
        .NEW_TOKENS_BITS(NEW_TOKENS_BITS)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .add_en   (conn == CONN_GOOD || conn == CONN_BAD),
        .tgt      (tgt),
        .sel_bad  (conn == CONN_BAD),
        .sign     (sign),
        .clear    (state == PUBLISH),
        .good_vals(good_vals),
        .bad_vals (bad_vals)
    );

endmodule
